// File: rtl/hilo_pkg.sv
// Shared op/state encodings and decode helpers for the HI/LO controller.
// Optional feature macro: HILO_MADD_EN (multiply-accumulate/subtract ops).
package hilo_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_MUL   = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ACC   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

`ifdef HILO_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  // Accumulating ops decode as NOP when the feature is compiled out.
  function automatic logic is_acc_op(op_e op);
    return MADD_EN && (op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
  endfunction

  function automatic logic is_mul_op(op_e op);
    return (op inside {OP_MULT, OP_MULTU, OP_MUL}) || is_acc_op(op);
  endfunction

  function automatic logic is_signed_op(op_e op);
    return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_sub_op(op_e op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/hilo_acc.sv
// Combinational {HI,LO} +/- product, wrapping modulo 2^(2*DATA_W).
module hilo_acc #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] hilo,
  input  logic [2*DATA_W-1:0] prod,
  input  logic                is_sub,
  output logic [2*DATA_W-1:0] sum
);

  assign sum = is_sub ? (hilo - prod) : (hilo + prod);

endmodule

// File: rtl/hilo_ctrl.sv
// EX-stage multiply controller: issues to the 2-cycle multiplier, owns HI/LO.
// Optional feature macro: HILO_MADD_EN enables MADD*/MSUB* via the ACC state.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [3:0]          op_i,
  input  logic [DATA_W-1:0]   rs_i,
  input  logic [DATA_W-1:0]   rt_i,
  input  logic                flush_i,
  input  logic                pipe_hold_i,
  output logic                mul_start_o,
  output logic                mul_signed_o,
  output logic [DATA_W-1:0]   mul_a_o,
  output logic [DATA_W-1:0]   mul_b_o,
  input  logic [2*DATA_W-1:0] mul_result_i,
  input  logic                mul_ready_i,
  output logic                stall_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                gpr_we_o,
  output logic [DATA_W-1:0]   gpr_wdata_o
);

  state_e            state;
  op_e               op_in, op_q;
  logic [DATA_W-1:0] a_q, b_q, hi, lo, gpr_q;
  logic              sgn_q;
  logic              take, issue, commit_ok;

  assign op_in     = op_e'(op_i);
  assign take      = (state == S_IDLE) && valid_i && !flush_i;
  assign issue     = take && is_mul_op(op_in);
  assign commit_ok = (state == S_WAIT) && mul_ready_i && !flush_i;

`ifdef HILO_MADD_EN
  logic [2*DATA_W-1:0] prod_q, acc_sum;

  hilo_acc #(.DATA_W(DATA_W)) u_acc (
    .hilo   ({hi, lo}),
    .prod   (prod_q),
    .is_sub (is_sub_op(op_q)),
    .sum    (acc_sum)
  );
`endif

  always_comb begin
    mul_start_o  = issue;
    mul_signed_o = (state == S_IDLE) ? (issue && is_signed_op(op_in)) : sgn_q;
    mul_a_o      = (state == S_IDLE) ? rs_i : a_q;
    mul_b_o      = (state == S_IDLE) ? rt_i : b_q;
    hi_o         = hi;
    lo_o         = lo;
    gpr_we_o     = (op_q == OP_MUL) && (commit_ok || state == S_DONE);
    gpr_wdata_o  = '0;
    if (gpr_we_o)
      gpr_wdata_o = (state == S_WAIT) ? mul_result_i[DATA_W-1:0] : gpr_q;
    case (state)
      S_IDLE:  stall_o = issue;
      // Accumulating ops keep EX held through the capture cycle.
      S_WAIT:  stall_o = !(mul_ready_i && !is_acc_op(op_q));
      S_DRAIN: stall_o = valid_i && is_mul_op(op_in);
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= OP_NOP;
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      gpr_q <= '0;
`ifdef HILO_MADD_EN
      prod_q <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            a_q   <= rs_i;
            b_q   <= rt_i;
            op_q  <= op_in;
            sgn_q <= is_signed_op(op_in);
            state <= S_WAIT;
          end else if (take) begin
            if (op_in == OP_MTHI) hi <= rs_i;
            if (op_in == OP_MTLO) lo <= rs_i;
          end
        end
        S_WAIT: begin
          if (mul_ready_i) begin
            if (flush_i) begin
              state <= S_IDLE;
            end else if (is_acc_op(op_q)) begin
`ifdef HILO_MADD_EN
              prod_q <= mul_result_i;
              state  <= S_ACC;
`else
              state  <= S_IDLE;
`endif
            end else begin
              if (op_q == OP_MUL) gpr_q <= mul_result_i[DATA_W-1:0];
              else                {hi, lo} <= mul_result_i;
              state <= pipe_hold_i ? S_DONE : S_IDLE;
            end
          end else if (flush_i) begin
            // Multiplier cannot abort; swallow the in-flight product.
            state <= S_DRAIN;
          end
        end
`ifdef HILO_MADD_EN
        S_ACC: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            {hi, lo} <= acc_sum;
            state    <= pipe_hold_i ? S_DONE : S_IDLE;
          end
        end
`endif
        S_DRAIN: if (mul_ready_i) state <= S_IDLE;
        S_DONE:  if (flush_i || !pipe_hold_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a 2-cycle multiplier model.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_i, flush_i, pipe_hold_i;
  logic [3:0]     op_i;
  logic [W-1:0]   rs_i, rt_i;
  logic           mul_start_o, mul_signed_o, mul_ready_i;
  logic [W-1:0]   mul_a_o, mul_b_o;
  logic [2*W-1:0] mul_result_i;
  logic           stall_o, gpr_we_o;
  logic [W-1:0]   hi_o, lo_o, gpr_wdata_o;

  int total = 0;
  int bad   = 0;

  hilo_ctrl #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .op_i         (op_i),
    .rs_i         (rs_i),
    .rt_i         (rt_i),
    .flush_i      (flush_i),
    .pipe_hold_i  (pipe_hold_i),
    .mul_start_o  (mul_start_o),
    .mul_signed_o (mul_signed_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_result_i (mul_result_i),
    .mul_ready_i  (mul_ready_i),
    .stall_o      (stall_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .gpr_we_o     (gpr_we_o),
    .gpr_wdata_o  (gpr_wdata_o)
  );

  always #5 clk = ~clk;

  // Multiplier model: ready two cycles after start; product formed from the
  // operands presented during the ready cycle, so unstable operands show up.
  logic r1, r2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= 1'b0;
      r2 <= 1'b0;
    end else begin
      r1 <= mul_start_o;
      r2 <= r1;
    end
  end

  function automatic logic [63:0] mulf(logic [31:0] a, logic [31:0] b, logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  assign mul_ready_i  = r2;
  assign mul_result_i = r2 ? mulf(mul_a_o, mul_b_o, mul_signed_o) : '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(logic v, op_e op, logic [31:0] a, logic [31:0] b,
                        logic fl, logic hold);
    valid_i     = v;
    op_i        = op;
    rs_i        = a;
    rt_i        = b;
    flush_i     = fl;
    pipe_hold_i = hold;
    #4;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 0; op_i = OP_NOP; rs_i = 0; rt_i = 0; flush_i = 0; pipe_hold_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("rst_start", mul_start_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_hilo", {hi_o, lo_o}, 0);
    chk("rst_gpr_we", gpr_we_o, 0);
    chk("rst_signed", mul_signed_o, 0);
    nxt;

    // flush in IDLE: no issue, no MTHI write
    set_in(1, OP_MULT, 5, 6, 1, 0);
    chk("idle_flush_start", mul_start_o, 0);
    chk("idle_flush_stall", stall_o, 0);
    nxt;
    set_in(1, OP_MTHI, 9, 0, 1, 0);
    nxt;
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("idle_flush_mthi", hi_o, 0);
    nxt;

    // MULT -2 * 3
    set_in(1, OP_MULT, 32'hFFFF_FFFE, 3, 0, 0);
    chk("mult_c0_start", mul_start_o, 1);
    chk("mult_c0_stall", stall_o, 1);
    chk("mult_c0_signed", mul_signed_o, 1);
    nxt;
    set_in(1, OP_MULT, 32'h1234_5678, 9, 0, 0);
    chk("mult_c1_stall", stall_o, 1);
    chk("mult_c1_start", mul_start_o, 0);
    chk("mult_c1_a_hold", mul_a_o, 32'hFFFF_FFFE);
    nxt;
    set_in(1, OP_MULT, 32'h1234_5678, 9, 0, 0);
    chk("mult_c2_stall", stall_o, 0);
    nxt;
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    nxt;

    // MULTU same operands
    set_in(1, OP_MULTU, 32'hFFFF_FFFE, 3, 0, 0);
    chk("multu_c0_start", mul_start_o, 1);
    chk("multu_c0_signed", mul_signed_o, 0);
    nxt;
    set_in(1, OP_MULTU, 32'hFFFF_FFFE, 3, 0, 0);
    chk("multu_c1_signed", mul_signed_o, 0);
    nxt;
    set_in(1, OP_MULTU, 32'hFFFF_FFFE, 3, 0, 0);
    chk("multu_c2_signed", mul_signed_o, 0);
    chk("multu_c2_stall", stall_o, 0);
    nxt;
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("multu_hilo", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
    nxt;

    // MTHI / MTLO
    set_in(1, OP_MTHI, 1, 0, 0, 0);
    chk("mthi_stall", stall_o, 0);
    chk("mthi_start", mul_start_o, 0);
    nxt;
    set_in(1, OP_MTLO, 32'hFFFF_FFFF, 0, 0, 0);
    nxt;

`ifdef HILO_MADD_EN
    // MADDU 1*1 on {1, FFFFFFFF}
    set_in(1, OP_MADDU, 1, 1, 0, 0);
    chk("mt_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFF);
    chk("maddu_c0_start", mul_start_o, 1);
    nxt;
    set_in(1, OP_MADDU, 1, 1, 0, 0);
    nxt;
    set_in(1, OP_MADDU, 1, 1, 0, 0);
    chk("maddu_c2_stall", stall_o, 1);
    nxt;
    set_in(1, OP_MADDU, 1, 1, 0, 0);
    chk("maddu_c3_stall", stall_o, 0);
    chk("maddu_c3_start", mul_start_o, 0);
    nxt;
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("maddu_hilo", {hi_o, lo_o}, 64'h0000_0002_0000_0000);
    nxt;

    // MSUB 1*2
    for (int c = 0; c < 4; c++) begin
      set_in(1, OP_MSUB, 1, 2, 0, 0);
      if (c == 0) chk("msub_c0_signed", mul_signed_o, 1);
      if (c == 3) chk("msub_c3_stall", stall_o, 0);
      nxt;
    end
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("msub_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    nxt;
`else
    // accumulating ops decode as NOP
    set_in(1, OP_MADDU, 1, 1, 0, 0);
    chk("mt_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFF);
    chk("maddu_nop_start", mul_start_o, 0);
    chk("maddu_nop_stall", stall_o, 0);
    nxt;
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("maddu_nop_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFF);
    nxt;
    set_in(1, OP_MTLO, 32'hFFFF_FFFE, 0, 0, 0);
    nxt;
`endif
    // {HI,LO} is now {1, FFFFFFFE} in both builds

    // MUL 7 * -3, no hold
    set_in(1, OP_MUL, 7, 32'hFFFF_FFFD, 0, 0);
    nxt;
    set_in(1, OP_MUL, 7, 32'hFFFF_FFFD, 0, 0);
    nxt;
    set_in(1, OP_MUL, 7, 32'hFFFF_FFFD, 0, 0);
    chk("mul_we", gpr_we_o, 1);
    chk("mul_wdata", gpr_wdata_o, 32'hFFFF_FFEB);
    nxt;
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("mul_we_off", gpr_we_o, 0);
    chk("mul_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    nxt;

    // MUL 0x10000^2 with hold for 3 cycles after ready
    set_in(1, OP_MUL, 32'h1_0000, 32'h1_0000, 0, 0);
    nxt;
    set_in(1, OP_MUL, 32'h1_0000, 32'h1_0000, 0, 0);
    nxt;
    set_in(1, OP_MUL, 32'h1_0000, 32'h1_0000, 0, 1);
    chk("mulh_c2_we", gpr_we_o, 1);
    chk("mulh_c2_wdata", gpr_wdata_o, 0);
    chk("mulh_c2_stall", stall_o, 0);
    nxt;
    for (int c = 0; c < 4; c++) begin
      set_in(1, OP_MUL, 32'h1_0000, 32'h1_0000, 0, (c < 3));
      chk("mulh_done_we", gpr_we_o, 1);
      chk("mulh_done_start", mul_start_o, 0);
      nxt;
    end
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("mulh_we_off", gpr_we_o, 0);
    chk("mulh_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    nxt;

    // flush in WAIT -> DRAIN, then re-issue
    set_in(1, OP_MULT, 5, 7, 0, 0);
    chk("fl_c0_start", mul_start_o, 1);
    nxt;
    set_in(1, OP_MULT, 3, 4, 1, 0);
    chk("fl_c1_stall", stall_o, 1);
    nxt;
    set_in(1, OP_MULT, 3, 4, 0, 0);
    chk("fl_c2_stall", stall_o, 1);
    chk("fl_c2_start", mul_start_o, 0);
    nxt;
    set_in(1, OP_MULT, 3, 4, 0, 0);
    chk("fl_c3_start", mul_start_o, 1);
    chk("fl_c3_a", mul_a_o, 3);
    chk("fl_hilo_kept", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    nxt;
    set_in(1, OP_MULT, 3, 4, 0, 0);
    chk("fl_c4_stall", stall_o, 1);
    nxt;
    set_in(1, OP_MULT, 3, 4, 0, 0);
    chk("fl_c5_stall", stall_o, 0);
    nxt;
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("fl_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_000C);
    nxt;

    // reset while in WAIT
    set_in(1, OP_MULT, 2, 3, 0, 0);
    nxt;
    rst = 1'b1;
    set_in(1, OP_MULT, 2, 3, 0, 0);
    nxt;
    rst = 1'b0;
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("rw_stall", stall_o, 0);
    chk("rw_start", mul_start_o, 0);
    chk("rw_hilo", {hi_o, lo_o}, 0);
    nxt;
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("rw_idle_start", mul_start_o, 0);
    chk("rw_no_stale", {hi_o, lo_o}, 0);
    nxt;
    for (int c = 0; c < 3; c++) begin
      set_in(1, OP_MULT, 2, 3, 0, 0);
      if (c == 0) chk("rw_new_start", mul_start_o, 1);
      nxt;
    end
    set_in(0, OP_NOP, 0, 0, 0, 0);
    chk("rw_new_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_0006);
    nxt;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
